// File: rtl/timer_display_scan.sv
// Six-digit 7-segment scanner for hr:min:sec with per-frame input snapshot.
// Optional expiry blink on 00:00:00 when TIMER_DISP_BLINK_EN is defined.
module timer_display_scan #(
   parameter int unsigned P_SCAN_DIV   = 1000,
   parameter int unsigned P_BLINK_HALF = 32
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic [4:0] i_hr,
   output logic [6:0] o_seg,
   output logic       o_dp,
   output logic [5:0] o_an
);

   localparam int unsigned CntW = $clog2(P_SCAN_DIV);

   if (P_SCAN_DIV < 2) begin : g_bad_scan_div
      $error("P_SCAN_DIV must be at least 2");
   end
   if (P_BLINK_HALF < 1) begin : g_bad_blink_half
      $error("P_BLINK_HALF must be at least 1");
   end

   function automatic logic [3:0] bcd_tens(input logic [5:0] v);
      logic [5:0] t;
      t = v / 6'd10;
      return t[3:0];
   endfunction

   function automatic logic [3:0] bcd_ones(input logic [5:0] v);
      logic [5:0] t;
      t = v % 6'd10;
      return t[3:0];
   endfunction

   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [5:0]      snap_sec_q, snap_min_q;
   logic [4:0]      snap_hr_q;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [5:0]      an_q, an_d;
   logic            scan_end, frame_end, snap_zero, blank;

   assign scan_end  = (cnt_q == CntW'(P_SCAN_DIV - 1));
   assign frame_end = scan_end && (idx_q == 3'd5);
   assign snap_zero = (snap_sec_q == 6'd0) && (snap_min_q == 6'd0) && (snap_hr_q == 5'd0);

   always_comb begin
      cnt_d = scan_end ? '0 : cnt_q + CntW'(1);
      idx_d = idx_q;
      if (scan_end) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
   end

`ifdef TIMER_DISP_BLINK_EN
   localparam int unsigned FcW = $clog2(2 * P_BLINK_HALF);

   logic [FcW-1:0] fc_q, fc_d;

   // Held at 0 while time remains so blinking always begins in the on-phase.
   always_comb begin
      fc_d = fc_q;
      if (!snap_zero) begin
         fc_d = '0;
      end else if (frame_end) begin
         fc_d = (fc_q == FcW'(2 * P_BLINK_HALF - 1)) ? '0 : fc_q + FcW'(1);
      end
   end

   assign blank = snap_zero && (fc_q >= FcW'(P_BLINK_HALF));

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         fc_q <= '0;
      end else begin
         fc_q <= fc_d;
      end
   end
`else
   assign blank = 1'b0;
`endif

   logic [3:0] dig;
   logic       bad;

   always_comb begin
      dig = 4'd0;
      bad = 1'b0;
      unique case (idx_q)
         3'd0: begin dig = bcd_ones(snap_sec_q);        bad = snap_sec_q > 6'd59; end
         3'd1: begin dig = bcd_tens(snap_sec_q);        bad = snap_sec_q > 6'd59; end
         3'd2: begin dig = bcd_ones(snap_min_q);        bad = snap_min_q > 6'd59; end
         3'd3: begin dig = bcd_tens(snap_min_q);        bad = snap_min_q > 6'd59; end
         3'd4: begin dig = bcd_ones({1'b0, snap_hr_q}); bad = snap_hr_q > 5'd23;  end
         3'd5: begin dig = bcd_tens({1'b0, snap_hr_q}); bad = snap_hr_q > 5'd23;  end
         default: begin dig = 4'd0; bad = 1'b0; end
      endcase
   end

   always_comb begin
      seg_d = bad ? 7'h40 : seg_lut(dig);
      dp_d  = (idx_q == 3'd2) || (idx_q == 3'd4);
      an_d  = ~(6'b000001 << idx_q);
      if (blank) begin
         seg_d = 7'h00;
         dp_d  = 1'b0;
         an_d  = 6'h3F;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         snap_sec_q <= 6'd0;
         snap_min_q <= 6'd0;
         snap_hr_q  <= 5'd0;
         seg_q      <= 7'h00;
         dp_q       <= 1'b0;
         an_q       <= 6'h3F;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (frame_end) begin
            snap_sec_q <= i_sec;
            snap_min_q <= i_min;
            snap_hr_q  <= i_hr;
         end
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign o_seg = seg_q;
   assign o_dp  = dp_q;
   assign o_an  = an_q;

endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized bench for timer_display_scan against a frame-level display model.
// Follows TIMER_DISP_BLINK_EN the same way the design does.
module tb_timer_display_scan;

   localparam int SCAN  = 4;
   localparam int BHALF = 2;
   localparam int FRAME = 6 * SCAN;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [5:0] sec = 6'd0;
   logic [5:0] min = 6'd0;
   logic [4:0] hr  = 5'd0;
   logic [6:0] seg;
   logic       dp;
   logic [5:0] an;

   int checks = 0;
   int errors = 0;

   // Model state: edges since reset release, frame snapshot, zero-frame run length.
   int         m_e = 0;
   int         m_zrun = 0;
   int         m_sec = 0, m_min = 0, m_hr = 0;
   logic [6:0] seg_tab [10];

   timer_display_scan #(
      .P_SCAN_DIV  (SCAN),
      .P_BLINK_HALF(BHALF)
   ) dut (
      .i_clk (clk),
      .i_rstn(rstn),
      .i_sec (sec),
      .i_min (min),
      .i_hr  (hr),
      .o_seg (seg),
      .o_dp  (dp),
      .o_an  (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got an/seg/dp=%h/%h/%b expected %h/%h/%b", tag, m_e,
                  got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
      end
   endtask

   function automatic logic [13:0] expect_digit(int d);
      int         v, lim, digit;
      logic [5:0] a;
      logic [6:0] s;
      logic       p;
      v     = (d / 2 == 0) ? m_sec : (d / 2 == 1) ? m_min : m_hr;
      lim   = (d / 2 == 2) ? 23 : 59;
      digit = (d % 2 == 1) ? v / 10 : v % 10;
      s     = (v > lim) ? 7'h40 : seg_tab[digit];
      p     = (d == 2) || (d == 4);
      a     = 6'h3F;
      a[d]  = 1'b0;
`ifdef TIMER_DISP_BLINK_EN
      if (m_sec == 0 && m_min == 0 && m_hr == 0 && (m_zrun % (2 * BHALF)) >= BHALF)
         return {6'h3F, 7'h00, 1'b0};
`endif
      return {a, s, p};
   endfunction

   task automatic tick(input string tag);
      logic       r;
      int         s, m, h;
      logic [13:0] exp;
      r = rstn;
      s = sec;
      m = min;
      h = hr;
      @(posedge clk);
      #1;
      if (!r) begin
         m_e = 0; m_zrun = 0; m_sec = 0; m_min = 0; m_hr = 0;
         exp = {6'h3F, 7'h00, 1'b0};
      end else begin
         m_e++;
         exp = expect_digit(((m_e - 1) / SCAN) % 6);
         if (m_e % FRAME == 0) begin
            if (s == 0 && m == 0 && h == 0 && m_sec == 0 && m_min == 0 && m_hr == 0)
               m_zrun++;
            else
               m_zrun = 0;
            m_sec = s; m_min = m; m_hr = h;
         end
      end
      check(tag, {an, seg, dp}, exp);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      hr  = 5'(h);
      min = 6'(m);
      sec = 6'(s);
   endtask

   task automatic rand_time();
      int mode;
      mode = int'($urandom_range(0, 9));
      if (mode < 2)      set_time(0, 0, 0);
      else if (mode < 4) set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                                  int'($urandom_range(0, 63)));
      else               set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                  int'($urandom_range(0, 59)));
   endtask

   initial begin
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

      // Reset held with 12:34:56 on the inputs; first frame must still read zeros.
      set_time(12, 34, 56);
      rstn = 1'b0;
      run(3, "reset");
      rstn = 1'b1;
      run(FRAME, "first_frame");
      run(FRAME, "steady_123456");

      // Mid-frame change at idx2 must not tear the current frame.
      run(2 * SCAN, "pre_change");
      set_time(1, 2, 3);
      run(4 * SCAN + FRAME, "change_mid");

      set_time(5, 61, 7);
      run(2 * FRAME, "min_range");
      set_time(24, 59, 63);
      run(2 * FRAME, "hr_sec_range");

      set_time(0, 0, 0);
      run(6 * FRAME, "expired");
      set_time(0, 0, 1);
      run(2 * FRAME, "resume");

      // Reset in the middle of a frame, then restart from zeros.
      run(3 * SCAN + 2, "pre_reset");
      rstn = 1'b0;
      run(2, "mid_reset");
      rstn = 1'b1;
      run(2 * FRAME, "after_reset");

      for (int i = 0; i < 2400; i++) begin
         if ($urandom_range(0, 29) == 0) rand_time();
         if ($urandom_range(0, 599) == 0) begin
            rstn = 1'b0;
            run(int'($urandom_range(1, 3)), "rand_reset");
            rstn = 1'b1;
         end
         tick("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
